adcdac_2g_ctrl_resp: RTL and testbench
======================================

Name: adcdac_2g_ctrl_resp

Overview:
- Board-side responder for the ADC/DAC 2G serial control link. It deserializes command bytes that the FPGA-side controller sends over the ZDOK rx line.
- It decodes them into single-cycle register read/write strobes on a local register bus, and serializes read responses back on the ZDOK tx line.
- Differential buffers (IBUFDS/OBUFDS) live in the wrapper; this block sees single-ended lines.

Parameters:
- CLKS_PER_BIT, 16, fpga_clk cycles per serial bit (even, >=4)
- TIMEOUT_BITS, 32, bit periods allowed between write command byte and write data byte

Ports:
- fpga_clk  in  1  block clock
- fpga_rst  in  1  synchronous active-high reset
- zdok_rx_data  in  1  serial command line from host (idle high)
- zdok_tx_data  out  1  serial response line to host (idle high)
- reg_addr  out  7  register address
- reg_wdata  out  8  register write data
- reg_we  out  1  write strobe, 1-cycle pulse
- reg_re  out  1  read strobe, 1-cycle pulse
- reg_rdata  in  8  read data, valid the cycle after reg_re
- err_cnt  out  8  saturating protocol error count
- busy  out  1  high whenever frame FSM is not in S_CMD or tx serializer active

Behaviour:
- Reset values:
  - zdok_tx_data=1; reg_we, reg_re, busy = 0; reg_addr, reg_wdata, err_cnt = 0.
  - rx synchronizer flops = 1; all FSMs idle.
  - Reset mid-frame or mid-transmit aborts immediately; tx line is high on the edge after reset.
- Line format (both directions):
  - Start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit lasts CLKS_PER_BIT cycles.
- Rx:
  - 2-flop synchronizer on zdok_rx_data.
  - Idle until synced line = 0, wait CLKS_PER_BIT/2 cycles, recheck. Still 1 -> false start, return to idle, no error counted.
  - Then sample each data bit every CLKS_PER_BIT cycles, then sample the stop bit.
  - Stop=1 -> byte_valid pulse (internal, 1 cycle) in the cycle after the stop sample.
  - Stop=0 -> framing error; err_cnt+1; rx waits for synced line = 1 before rearming.
- Frame FSM states: S_CMD, S_WDATA, S_RD, S_CAP, S_RESP.
  - S_CMD, byte b, b[7]=0 (write): latch reg_addr=b[6:0], go S_WDATA, clear timeout counter.
  - S_CMD, byte b, b[7]=1 (read): latch reg_addr=b[6:0], go S_RD.
  - S_WDATA, byte d: reg_wdata=d, reg_we=1 for the single next cycle, return S_CMD.
  - S_WDATA timeout: TIMEOUT_BITS*CLKS_PER_BIT cycles without a byte -> err_cnt+1, return S_CMD, no strobe.
  - S_WDATA framing error: abort to S_CMD, no strobe; counted once only, even if timeout expires the same cycle.
  - S_RD: reg_re=1 for one cycle -> S_CAP.
  - S_CAP: capture reg_rdata into tx shift register, start tx -> S_RESP.
  - S_RESP: wait for tx done (10*CLKS_PER_BIT cycles) -> S_CMD.
  - Any byte completed while in S_RESP is discarded, err_cnt+1.
- Latency:
  - Write: reg_we asserts 1 cycle after byte_valid of the data byte.
  - Read: reg_re at byte_valid+1; rdata captured at +2; tx start bit on zdok_tx_data from +3.
- err_cnt:
  - Saturates at 255; no wrap.
  - At most one increment per cycle.
- reg_addr and reg_wdata hold their last values between transactions.

Decomposition:
- Shared package adcdac_2g_ctrl_pkg holds:
  - frame FSM state enum;
  - READ_FLAG bit index (7);
  - frame bit count (10);
  - line IDLE level (1).
- The host-side controller uses the same package.
- One sub-module: adcdac_2g_ctrl_bit_rx (synchronizer, start validation, mid-bit sampling, byte_valid/frame_err outputs).
- Tx serializer and frame FSM stay in the top.

Test Plan:
- Write: send 0x15 then 0xA5 (CLKS_PER_BIT=16) -> reg_addr=0x15, reg_wdata=0xA5, reg_we high exactly 1 cycle, 1 cycle after the second byte_valid; err_cnt=0.
- Read: send 0x83 with reg_rdata=0x3C -> reg_re 1 cycle with reg_addr=0x03; zdok_tx_data emits 0,0,0,1,1,1,1,0,0,1 at 16-cycle spacing, starting byte_valid+3; busy low after.
- Glitch: rx low for 5 cycles then high -> no byte, no error, FSM stays S_CMD.
- Framing: byte with stop bit 0 after write command 0x01 -> no reg_we, err_cnt=1, FSM S_CMD; next valid write accepted.
- Timeout: write command 0x02 then silence for 32*16 cycles -> err_cnt+1, no reg_we; 260 such errors -> err_cnt=255.
- Reset: assert fpga_rst mid-response bit 4 -> next cycle zdok_tx_data=1, busy=0, err_cnt=0; a subsequent read works normally.

Source files
------------

// File: rtl/adcdac_2g_ctrl_pkg.sv
// Shared definitions for the ADC/DAC 2G serial control link.
// Both this board-side responder and the host-side controller import this package.
package adcdac_2g_ctrl_pkg;

    localparam int   READ_FLAG  = 7;
    localparam int   FRAME_BITS = 10;
    localparam logic LINE_IDLE  = 1'b1;

    typedef enum logic [2:0] {
        S_CMD,
        S_WDATA,
        S_RD,
        S_CAP,
        S_RESP
    } frame_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_e;

    // Error counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/adcdac_2g_ctrl_bit_rx.sv
// Serial byte receiver: 2-flop synchronizer, start-bit validation at mid-bit,
// LSB-first data sampling and stop-bit check producing byte_valid / frame_err pulses.
module adcdac_2g_ctrl_bit_rx
    import adcdac_2g_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    logic             sync1_q, sync2_q;
    logic             rx_s;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             half_done, bit_done;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= LINE_IDLE;
            sync2_q <= LINE_IDLE;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s      = sync2_q;
    assign half_done = (cnt_q == CNT_W'(HALF - 1));
    assign bit_done  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start that has gone high again by mid-bit is a glitch, not a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:      if (rx_s != LINE_IDLE) state_d = RX_START;
            RX_START:     if (half_done) state_d = (rx_s == LINE_IDLE) ? RX_IDLE : RX_DATA;
            RX_DATA:      if (bit_done && bit_idx_q == 3'd7) state_d = RX_STOP;
            RX_STOP:      if (bit_done) state_d = (rx_s == LINE_IDLE) ? RX_IDLE : RX_WAIT_IDLE;
            RX_WAIT_IDLE: if (rx_s == LINE_IDLE) state_d = RX_IDLE;
            default:      state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            RX_START: begin
                if (half_done) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            RX_DATA: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    valid_d = (rx_s == LINE_IDLE);
                    ferr_d  = (rx_s != LINE_IDLE);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/adcdac_2g_ctrl_resp.sv
// Board-side responder: turns received command bytes into register bus strobes
// and serializes read data back to the host on the tx line.
module adcdac_2g_ctrl_resp
    import adcdac_2g_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic       fpga_clk,
    input  logic       fpga_rst,
    input  logic       zdok_rx_data,
    output logic       zdok_tx_data,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic [7:0] err_cnt,
    output logic       busy
);

    localparam int CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int TO_CYCLES  = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W       = $clog2(TO_CYCLES);

    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_ferr;

    frame_state_e     state_q, state_d;
    logic [6:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [7:0]       err_q, err_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             err_inc;
    logic             re_c;
    logic             tx_start;
    logic             timeout;

    logic             tx_line_q;
    logic             tx_active_q;
    logic [8:0]       tx_shift_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [3:0]       tx_bits_q;
    logic             tx_bit_done;
    logic             tx_done;

    adcdac_2g_ctrl_bit_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_rx (
        .clk_i        (fpga_clk),
        .rst_i        (fpga_rst),
        .rx_i         (zdok_rx_data),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_ferr)
    );

    assign timeout     = (to_cnt_q == TO_W'(TO_CYCLES - 1));
    assign tx_bit_done = (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign tx_done     = tx_active_q && tx_bit_done && (tx_bits_q == 4'(FRAME_BITS - 1));

    always_ff @(posedge fpga_clk) begin
        if (fpga_rst) begin
            state_q <= S_CMD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CMD:   if (rx_valid) state_d = rx_byte[READ_FLAG] ? S_RD : S_WDATA;
            S_WDATA: if (rx_valid || rx_ferr || timeout) state_d = S_CMD;
            S_RD:    state_d = S_CAP;
            S_CAP:   state_d = S_RESP;
            S_RESP:  if (tx_done) state_d = S_CMD;
            default: state_d = S_CMD;
        endcase
    end

    // A framing error is always counted, and it absorbs a timeout landing on the same cycle.
    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        to_cnt_d = '0;
        err_inc  = 1'b0;
        re_c     = 1'b0;
        tx_start = 1'b0;
        case (state_q)
            S_CMD: begin
                if (rx_valid) addr_d = rx_byte[6:0];
            end
            S_WDATA: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (rx_valid) begin
                    wdata_d = rx_byte;
                    we_d    = 1'b1;
                end else if (timeout && !rx_ferr) begin
                    err_inc = 1'b1;
                end
            end
            S_RD:    re_c = 1'b1;
            S_CAP:   tx_start = 1'b1;
            S_RESP:  if (rx_valid) err_inc = 1'b1;
            default: ;
        endcase
        if (rx_ferr) err_inc = 1'b1;
        err_d = err_inc ? sat_inc8(err_q) : err_q;
    end

    always_ff @(posedge fpga_clk) begin
        if (fpga_rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            err_q    <= '0;
            to_cnt_q <= '0;
        end else begin
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            err_q    <= err_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // The start bit goes straight onto the line; the shifter holds data plus stop bit.
    always_ff @(posedge fpga_clk) begin
        if (fpga_rst) begin
            tx_line_q   <= LINE_IDLE;
            tx_active_q <= 1'b0;
            tx_shift_q  <= '1;
            tx_cnt_q    <= '0;
            tx_bits_q   <= '0;
        end else if (tx_start) begin
            tx_line_q   <= ~LINE_IDLE;
            tx_active_q <= 1'b1;
            tx_shift_q  <= {LINE_IDLE, reg_rdata};
            tx_cnt_q    <= '0;
            tx_bits_q   <= '0;
        end else if (tx_active_q) begin
            if (tx_bit_done) begin
                tx_cnt_q <= '0;
                if (tx_bits_q == 4'(FRAME_BITS - 1)) begin
                    tx_active_q <= 1'b0;
                    tx_line_q   <= LINE_IDLE;
                end else begin
                    tx_line_q  <= tx_shift_q[0];
                    tx_shift_q <= {LINE_IDLE, tx_shift_q[8:1]};
                    tx_bits_q  <= tx_bits_q + 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

    assign zdok_tx_data = tx_line_q;
    assign reg_addr     = addr_q;
    assign reg_wdata    = wdata_q;
    assign reg_we       = we_q;
    assign reg_re       = re_c;
    assign err_cnt      = err_q;
    assign busy         = (state_q != S_CMD) || tx_active_q;

endmodule

// File: tb/tb_adcdac_2g_ctrl_resp.sv
// Self-checking bench for adcdac_2g_ctrl_resp: directed serial frames, a transaction-level
// model that schedules expected bus/line activity per cycle, and literal spot checks.
module tb_adcdac_2g_ctrl_resp;

    localparam int CPB    = 16;
    localparam int TO_CYC = 32 * CPB;
    // Stop-bit sample lands 2 sync flops + 1 detect + half bit + 9 bits after the
    // first edge that sees the start bit; byte_valid is visible one cycle later.
    localparam int BV_LAT = 155;

    localparam int M_CMD   = 0;
    localparam int M_WDATA = 1;
    localparam int M_RESP  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rdata = 8'h00;
    logic       txLine;
    logic [6:0] regAddr;
    logic [7:0] regWdata;
    logic       regWe;
    logic       regRe;
    logic [7:0] errCnt;
    logic       busyOut;

    adcdac_2g_ctrl_resp #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(32)
    ) dut (
        .fpga_clk     (clk),
        .fpga_rst     (rst),
        .zdok_rx_data (rx),
        .zdok_tx_data (txLine),
        .reg_addr     (regAddr),
        .reg_wdata    (regWdata),
        .reg_we       (regWe),
        .reg_re       (regRe),
        .reg_rdata    (rdata),
        .err_cnt      (errCnt),
        .busy         (busyOut)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file behind the bus: read data appears the cycle after reg_re.
    logic [7:0] mem [128];
    always @(posedge clk) if (regRe === 1'b1) rdata <= mem[regAddr];

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Scheduled expectations, keyed by the cycle in which they become visible.
    bit weAt[int];
    bit reAt[int];
    bit errAt[int];
    bit busySet[int];
    bit busyClr[int];
    int addrAt[int];
    int wdataAt[int];
    int txAt[int];
    int rstCyc = -1;
    int mState = M_CMD;
    int mDeadline = 0;
    int mRespEnd = 0;

    function automatic void modelByte(input int n, input logic [7:0] b, input bit stopOk);
        int p;
        p = n + BV_LAT + 1;
        if (mState == M_WDATA && mDeadline < p) mState = M_CMD;
        if (mState == M_RESP && (p - 1) >= mRespEnd) mState = M_CMD;
        if (!stopOk) begin
            if (mState == M_WDATA) begin
                errAt.delete(mDeadline);
                busyClr.delete(mDeadline);
                busyClr[p] = 1'b1;
                mState = M_CMD;
            end
            errAt[p] = 1'b1;
        end else begin
            case (mState)
                M_CMD: begin
                    addrAt[p]  = int'(b[6:0]);
                    busySet[p] = 1'b1;
                    if (b[7]) begin
                        reAt[p]   = 1'b1;
                        txAt[p+2] = int'(mem[b[6:0]]);
                        mRespEnd  = p + 2 + 10 * CPB;
                        busyClr[mRespEnd] = 1'b1;
                        mState = M_RESP;
                    end else begin
                        mDeadline = p + TO_CYC;
                        errAt[mDeadline]   = 1'b1;
                        busyClr[mDeadline] = 1'b1;
                        mState = M_WDATA;
                    end
                end
                M_WDATA: begin
                    wdataAt[p] = int'(b);
                    weAt[p]    = 1'b1;
                    errAt.delete(mDeadline);
                    busyClr.delete(mDeadline);
                    busyClr[p] = 1'b1;
                    mState = M_CMD;
                end
                default: errAt[p] = 1'b1;
            endcase
        end
    endfunction

    function automatic void modelReset(input int r);
        weAt.delete();
        reAt.delete();
        errAt.delete();
        busySet.delete();
        busyClr.delete();
        addrAt.delete();
        wdataAt.delete();
        txAt.delete();
        rstCyc = r + 1;
        mState = M_CMD;
    endfunction

    // Per-cycle compare against the model, sampled 2 time units after each rising edge.
    int         expErr = 0;
    int         expAddr = 0;
    int         expWdata = 0;
    bit         expBusy = 1'b0;
    int         txS = -1;
    logic [7:0] txB = 8'h00;
    logic       expTx;
    int         weCount = 0;
    int         lastWeCyc = -1;
    int         lastReCyc = -1;
    int         lastReAddr = -1;

    initial begin
        int k;
        forever begin
            @(posedge clk);
            #2;
            if (cyc == rstCyc) begin
                expErr = 0; expAddr = 0; expWdata = 0; expBusy = 1'b0; txS = -1;
            end
            if (errAt.exists(cyc) && expErr < 255) expErr++;
            if (addrAt.exists(cyc))  expAddr  = addrAt[cyc];
            if (wdataAt.exists(cyc)) expWdata = wdataAt[cyc];
            if (busyClr.exists(cyc)) expBusy  = 1'b0;
            if (busySet.exists(cyc)) expBusy  = 1'b1;
            if (txAt.exists(cyc)) begin
                txS = cyc;
                txB = 8'(txAt[cyc]);
            end
            expTx = 1'b1;
            if (txS >= 0) begin
                k = cyc - txS;
                if (k >= 10 * CPB) begin
                    txS = -1;
                end else begin
                    k = k / CPB;
                    if (k == 0)      expTx = 1'b0;
                    else if (k == 9) expTx = 1'b1;
                    else             expTx = txB[3'(k - 1)];
                end
            end
            if (regWe === 1'b1) begin weCount++; lastWeCyc = cyc; end
            if (regRe === 1'b1) begin lastReCyc = cyc; lastReAddr = int'(regAddr); end
            if (checking) begin
                checkOutput("tx_line",  32'(txLine),   32'(expTx));
                checkOutput("reg_we",   32'(regWe),    32'(weAt.exists(cyc)));
                checkOutput("reg_re",   32'(regRe),    32'(reAt.exists(cyc)));
                checkOutput("reg_addr", 32'(regAddr),  32'(expAddr));
                checkOutput("reg_wdata",32'(regWdata), 32'(expWdata));
                checkOutput("err_cnt",  32'(errCnt),   32'(expErr));
                checkOutput("busy",     32'(busyOut),  32'(expBusy));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 10-bit frame starting at the current falling edge.
    task automatic applyStimulus(input logic [7:0] b, input bit stopBit);
        modelByte(cyc, b, stopBit);
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      rx = 1'b0;
            else if (i == 9) rx = stopBit;
            else             rx = b[i-1];
            idle(CPB);
        end
        rx = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, n1, weBefore;
        logic [9:0] txPattern;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i * 37 + 11);
        mem[3] = 8'h3C;
        mem[5] = 8'hC5;

        idle(3);
        checkOutput("rst_tx",    32'(txLine),   32'd1);
        checkOutput("rst_busy",  32'(busyOut),  32'd0);
        checkOutput("rst_we",    32'(regWe),    32'd0);
        checkOutput("rst_re",    32'(regRe),    32'd0);
        checkOutput("rst_addr",  32'(regAddr),  32'd0);
        checkOutput("rst_wdata", 32'(regWdata), 32'd0);
        checkOutput("rst_err",   32'(errCnt),   32'd0);
        checking = 1'b1;
        rst = 1'b0;
        idle(10);

        $display("[TB] write 0x15 <- 0xA5");
        weBefore = weCount;
        applyStimulus(8'h15, 1'b1);
        n1 = cyc;
        applyStimulus(8'hA5, 1'b1);
        idle(4);
        checkOutput("wr_addr",   32'(regAddr),  32'h15);
        checkOutput("wr_wdata",  32'(regWdata), 32'hA5);
        checkOutput("wr_pulses", 32'(weCount - weBefore), 32'd1);
        checkOutput("wr_cycle",  32'(lastWeCyc), 32'(n1 + 156));
        checkOutput("wr_err",    32'(errCnt),   32'd0);

        $display("[TB] read 0x03 returns 0x3C");
        txPattern = 10'b10_0111_1000;
        n = cyc;
        applyStimulus(8'h83, 1'b1);
        idle(6);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("rd_txbit%0d", k), 32'(txLine), 32'(txPattern[k]));
            idle(CPB);
        end
        idle(n + 320 - cyc);
        checkOutput("rd_re_cycle", 32'(lastReCyc),  32'(n + 156));
        checkOutput("rd_re_addr",  32'(lastReAddr), 32'h03);
        checkOutput("rd_busy_end", 32'(busyOut),    32'd0);

        $display("[TB] 5-cycle glitch on rx");
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(40);
        checkOutput("glitch_err",  32'(errCnt),  32'd0);
        checkOutput("glitch_busy", 32'(busyOut), 32'd0);

        $display("[TB] framing error after write command");
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h55, 1'b0);
        idle(20);
        checkOutput("frm_err",  32'(errCnt),  32'd1);
        checkOutput("frm_busy", 32'(busyOut), 32'd0);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h77, 1'b1);
        idle(4);
        checkOutput("frm_next_wdata", 32'(regWdata), 32'h77);

        $display("[TB] byte during response is discarded");
        n = cyc;
        applyStimulus(8'h83, 1'b1);
        applyStimulus(8'h10, 1'b1);
        idle(4);
        checkOutput("disc_err",  32'(errCnt),  32'd2);
        checkOutput("disc_busy", 32'(busyOut), 32'd0);

        $display("[TB] write timeouts");
        for (int t = 0; t < 3; t++) begin
            applyStimulus(8'h02, 1'b1);
            idle(TO_CYC + 8);
        end
        checkOutput("to_err",  32'(errCnt),  32'd5);
        checkOutput("to_busy", 32'(busyOut), 32'd0);

        $display("[TB] error counter saturation");
        for (int t = 0; t < 252; t++) begin
            applyStimulus(8'h00, 1'b0);
            idle(6);
        end
        checkOutput("sat_err", 32'(errCnt), 32'd255);
        applyStimulus(8'h02, 1'b1);
        idle(TO_CYC + 8);
        checkOutput("sat_hold", 32'(errCnt), 32'd255);

        $display("[TB] reset during response bit 4");
        n = cyc;
        applyStimulus(8'h83, 1'b1);
        idle(n + 158 + 4 * CPB + 5 - cyc);
        rst = 1'b1;
        modelReset(cyc);
        idle(1);
        checkOutput("mid_rst_tx",   32'(txLine),  32'd1);
        checkOutput("mid_rst_busy", 32'(busyOut), 32'd0);
        checkOutput("mid_rst_err",  32'(errCnt),  32'd0);
        idle(1);
        rst = 1'b0;
        idle(4);
        n = cyc;
        applyStimulus(8'h85, 1'b1);
        idle(170);
        checkOutput("post_rst_re_cycle", 32'(lastReCyc),  32'(n + 156));
        checkOutput("post_rst_re_addr",  32'(lastReAddr), 32'h05);
        checkOutput("post_rst_busy",     32'(busyOut),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
